// File: rtl/switch_io_pkg.sv
// Shared types and helpers for the switch I/O controller.
package switch_io_pkg;

    // Request handshake states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Operation latched at request acceptance.
    typedef enum logic {
        OP_IN  = 1'b0,
        OP_OUT = 1'b1
    } op_t;

    // Width of a channel index; never below one bit so a single channel still has a port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/switch_io_ctrl_debounce.sv
// Synchroniser, debouncer and rising-edge pulse for the raw enter button.
module button_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    // Counter only has to reach DEB_CYCLES-1.
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   r_rise;
    logic                   w_enter_s;
    logic                   w_differs;
    logic                   w_flip;

    assign w_enter_s = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_enter_s != r_db);
    // A level change is accepted only once it has been seen on DEB_CYCLES consecutive edges.
    assign w_flip    = w_differs && (r_cnt == CNT_W'(DEB_CYCLES - 1));

    // Shift the asynchronous button through the synchroniser chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (w_flip) begin
            r_cnt <= '0;
            r_db  <= ~r_db;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Rise pulse is registered alongside the debounced level, so it is high in the
    // first cycle the debounced level reads 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rise <= 1'b0;
        end else begin
            r_rise <= w_flip && !r_db;
        end
    end

    assign level = r_db;
    assign rise  = r_rise;

endmodule

// File: rtl/switch_io_ctrl.sv
// Switch input / display output controller: one confirmed operation per enter press.
module switch_io_ctrl
    import switch_io_pkg::*;
#(
    parameter int DATA_W      = 18,
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_CH*DATA_W-1:0]       entrada,
    input  logic [ch_idx_w(NUM_CH)-1:0]    ch_sel,
    input  logic                           in,
    input  logic                           out,
    input  logic [DATA_W-1:0]              dado_out,
    input  logic                           enter,
    output logic                           sinal,
    output logic [DATA_W-1:0]              valor,
    output logic [DATA_W-1:0]              saida,
    output logic                           aguardando
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    state_t              r_state;
    op_t                 r_op;
    logic [CH_W-1:0]     r_ch;
    logic [DATA_W-1:0]   r_dout;
    logic                r_sinal;
    logic [DATA_W-1:0]   r_valor;
    logic [DATA_W-1:0]   r_saida;
    logic                r_aguardando;

    logic                w_level;
    logic                w_rise;
    logic [CH_W-1:0]     w_req_ch;
    logic [DATA_W-1:0]   w_sel_data;

    button_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (enter),
        .level   (w_level),
        .rise    (w_rise)
    );

    // Out-of-range channel requests fall back to channel 0.
    assign w_req_ch = (int'(ch_sel) >= NUM_CH) ? '0 : ch_sel;

    // Select the latched channel from the live switch bus at confirmation time.
    always_comb begin
        w_sel_data = entrada[DATA_W-1:0];
        for (int c = 1; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_sel_data = entrada[c*DATA_W +: DATA_W];
            end
        end
    end

    // Request FSM: accept in IDLE, complete on a debounced press, re-arm after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_op         <= OP_IN;
            r_ch         <= '0;
            r_dout       <= '0;
            r_sinal      <= 1'b0;
            r_valor      <= '0;
            r_saida      <= '0;
            r_aguardando <= 1'b0;
        end else begin
            r_sinal <= 1'b0;
            case (r_state)
                IDLE: begin
                    // IN wins when both requests are raised together.
                    if (in) begin
                        r_op         <= OP_IN;
                        r_ch         <= w_req_ch;
                        r_aguardando <= 1'b1;
                        r_state      <= WAIT_PRESS;
                    end else if (out) begin
                        r_op         <= OP_OUT;
                        r_dout       <= dado_out;
                        r_aguardando <= 1'b1;
                        r_state      <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    // Only a fresh 0->1 of the debounced button confirms; a held button never does.
                    if (w_rise) begin
                        if (r_op == OP_IN) begin
                            r_valor <= w_sel_data;
                        end else begin
                            r_saida <= r_dout;
                        end
                        r_sinal      <= 1'b1;
                        r_aguardando <= 1'b0;
                        r_state      <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    // Hold off new requests until the button is seen released.
                    if (!w_level) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sinal      = r_sinal;
    assign valor      = r_valor;
    assign saida      = r_saida;
    assign aguardando = r_aguardando;

endmodule

// File: tb/tb_switch_io_ctrl.sv
// Directed bench for switch_io_ctrl with DEB_CYCLES=4.
module tb_switch_io_ctrl;

    localparam int DW  = 18;
    localparam int NCH = 2;

    typedef struct {
        logic          in_v;
        logic          out_v;
        logic          ch;
        logic [DW-1:0] ch0;
        logic [DW-1:0] ch1;
        logic [DW-1:0] dout;
        int            press;
        int            exp_pulses;
        logic [DW-1:0] exp_valor;
        logic [DW-1:0] exp_saida;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH*DW-1:0] entrada = '0;
    logic [0:0]        ch_sel = '0;
    logic              in = 1'b0;
    logic              out = 1'b0;
    logic [DW-1:0]     dado_out = '0;
    logic              enter = 1'b0;
    logic              sinal;
    logic [DW-1:0]     valor;
    logic [DW-1:0]     saida;
    logic              aguardando;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    vec_t vecs [6];

    switch_io_ctrl #(
        .DATA_W      (DW),
        .NUM_CH      (NCH),
        .SYNC_STAGES (2),
        .DEB_CYCLES  (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .entrada    (entrada),
        .ch_sel     (ch_sel),
        .in         (in),
        .out        (out),
        .dado_out   (dado_out),
        .enter      (enter),
        .sinal      (sinal),
        .valor      (valor),
        .saida      (saida),
        .aguardando (aguardando)
    );

    always #5 clock = ~clock;

    // Each sinal pulse is one cycle wide, so it is seen on exactly one edge.
    always @(posedge clock) begin
        if (sinal === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int p0;
        entrada  = {v.ch1, v.ch0};
        ch_sel   = v.ch;
        dado_out = v.dout;
        in       = v.in_v;
        out      = v.out_v;
        step(1);
        chk($sformatf("v%0d_busy", idx), {31'd0, aguardando}, 32'd1);
        // Request inputs change after acceptance; the latched values must be used.
        in       = 1'b0;
        out      = 1'b0;
        dado_out = 18'h3FFFF;
        ch_sel   = ~v.ch;
        p0       = pulse_cnt;
        enter    = 1'b1;
        step(v.press);
        enter    = 1'b0;
        step(12);
        chk($sformatf("v%0d_pulses", idx), pulse_cnt - p0, v.exp_pulses);
        chk($sformatf("v%0d_valor", idx), {14'd0, valor}, {14'd0, v.exp_valor});
        chk($sformatf("v%0d_saida", idx), {14'd0, saida}, {14'd0, v.exp_saida});
        chk($sformatf("v%0d_idle", idx), {31'd0, aguardando}, 32'd0);
    endtask

    initial begin
        int p0;

        vecs[0] = '{in_v:1'b0, out_v:1'b1, ch:1'b0, ch0:18'h11111, ch1:18'h2A5A5, dout:18'h00123,
                    press:10, exp_pulses:1, exp_valor:18'h2A5A5, exp_saida:18'h00123};
        vecs[1] = '{in_v:1'b1, out_v:1'b0, ch:1'b0, ch0:18'h11111, ch1:18'h2A5A5, dout:18'h00000,
                    press:8,  exp_pulses:1, exp_valor:18'h11111, exp_saida:18'h00123};
        vecs[2] = '{in_v:1'b1, out_v:1'b1, ch:1'b1, ch0:18'h11111, ch1:18'h3C3C3, dout:18'h0ABCD,
                    press:20, exp_pulses:1, exp_valor:18'h3C3C3, exp_saida:18'h00123};
        vecs[3] = '{in_v:1'b0, out_v:1'b1, ch:1'b0, ch0:18'h11111, ch1:18'h3C3C3, dout:18'h3FFFF,
                    press:9,  exp_pulses:1, exp_valor:18'h3C3C3, exp_saida:18'h3FFFF};
        vecs[4] = '{in_v:1'b1, out_v:1'b0, ch:1'b1, ch0:18'h20000, ch1:18'h00001, dout:18'h00000,
                    press:8,  exp_pulses:1, exp_valor:18'h00001, exp_saida:18'h3FFFF};
        vecs[5] = '{in_v:1'b1, out_v:1'b0, ch:1'b0, ch0:18'h20000, ch1:18'h00001, dout:18'h00000,
                    press:8,  exp_pulses:1, exp_valor:18'h20000, exp_saida:18'h3FFFF};

        // Power-on reset state.
        step(2);
        chk("rst_sinal", {31'd0, sinal}, 32'd0);
        chk("rst_valor", {14'd0, valor}, 32'd0);
        chk("rst_saida", {14'd0, saida}, 32'd0);
        chk("rst_busy", {31'd0, aguardando}, 32'd0);
        reset_n = 1'b1;
        step(2);

        // IN on channel 1 with exact confirmation latency; in stays high while the button is held.
        entrada = {18'h2A5A5, 18'h11111};
        ch_sel  = 1'b1;
        in      = 1'b1;
        step(1);
        chk("lat_busy", {31'd0, aguardando}, 32'd1);
        p0    = pulse_cnt;
        enter = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step(1);
            if (e == 6) chk("lat_e6_sinal", {31'd0, sinal}, 32'd0);
            if (e == 7) begin
                chk("lat_e7_sinal", {31'd0, sinal}, 32'd1);
                chk("lat_e7_valor", {14'd0, valor}, {14'd0, 18'h2A5A5});
                chk("lat_e7_busy", {31'd0, aguardando}, 32'd0);
            end
            if (e == 8) chk("lat_e8_sinal", {31'd0, sinal}, 32'd0);
            if (e == 15) chk("lat_held_busy", {31'd0, aguardando}, 32'd0);
        end
        chk("lat_pulses", pulse_cnt - p0, 32'd1);
        in    = 1'b0;
        enter = 1'b0;
        step(12);

        // Table of complete request/press/release transactions.
        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Bounce shorter than the debounce window is ignored.
        entrada = {18'h12345, 18'h0F0F0};
        ch_sel  = 1'b1;
        in      = 1'b1;
        step(1);
        in = 1'b0;
        p0 = pulse_cnt;
        enter = 1'b1; step(3);
        enter = 1'b0; step(2);
        enter = 1'b1; step(3);
        enter = 1'b0; step(4);
        chk("bounce_pulses", pulse_cnt - p0, 32'd0);
        chk("bounce_busy", {31'd0, aguardando}, 32'd1);
        enter = 1'b1; step(8);
        enter = 1'b0; step(12);
        chk("stable_pulses", pulse_cnt - p0, 32'd1);
        chk("stable_valor", {14'd0, valor}, {14'd0, 18'h12345});

        // Button already held when IN and OUT arrive together.
        entrada = {18'h12345, 18'h0F0F0};
        enter   = 1'b1;
        step(10);
        ch_sel   = 1'b0;
        dado_out = 18'h15555;
        in       = 1'b1;
        out      = 1'b1;
        step(1);
        in  = 1'b0;
        out = 1'b0;
        p0  = pulse_cnt;
        step(15);
        chk("held_pulses", pulse_cnt - p0, 32'd0);
        enter = 1'b0;
        step(10);
        chk("held_rel_pulses", pulse_cnt - p0, 32'd0);
        chk("held_rel_busy", {31'd0, aguardando}, 32'd1);
        enter = 1'b1; step(10);
        enter = 1'b0; step(12);
        chk("held_pulses_end", pulse_cnt - p0, 32'd1);
        chk("held_valor", {14'd0, valor}, {14'd0, 18'h0F0F0});
        chk("held_saida", {14'd0, saida}, {14'd0, 18'h3FFFF});

        // Asynchronous reset in WAIT_PRESS aborts the request and clears outputs at once.
        entrada = {18'h3ABCD, 18'h0F0F0};
        ch_sel  = 1'b1;
        in      = 1'b1;
        step(1);
        in = 1'b0;
        chk("abort_busy", {31'd0, aguardando}, 32'd1);
        p0    = pulse_cnt;
        enter = 1'b1;
        step(4);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_valor_now", {14'd0, valor}, 32'd0);
        chk("abort_saida_now", {14'd0, saida}, 32'd0);
        chk("abort_busy_now", {31'd0, aguardando}, 32'd0);
        step(2);
        reset_n = 1'b1;
        step(15);
        enter = 1'b0;
        step(12);
        chk("abort_pulses", pulse_cnt - p0, 32'd0);
        chk("abort_valor", {14'd0, valor}, 32'd0);
        chk("abort_idle", {31'd0, aguardando}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
